// File: rtl/d_cache_direct_if.sv
// CPU data-port handshake and memory-port control signals for the direct-mapped data cache.
// The 64-bit memory data bus is bidirectional, so it stays a plain inout on the cache module.
interface d_cache_direct_if #(
  parameter int WORD_SIZE = 16
);
  logic                 d_readC;
  logic                 d_writeC;
  logic [WORD_SIZE-1:0] d_addressC;
  logic [WORD_SIZE-1:0] d_wdataC;
  logic [WORD_SIZE-1:0] d_rdataC;
  logic                 d_readyC;
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_addressM;

  modport master (
    output d_readC, d_writeC, d_addressC, d_wdataC,
    input  d_rdataC, d_readyC, d_readM, d_writeM, d_addressM
  );

  modport slave (
    input  d_readC, d_writeC, d_addressC, d_wdataC,
    output d_rdataC, d_readyC, d_readM, d_writeM, d_addressM
  );
endinterface

// File: rtl/d_cache_direct.sv
// Direct-mapped, write-through, write-allocate data cache with 4-word line refill/store bursts
// and hit/miss performance counters.
module d_cache_direct #(
  parameter int WORD_SIZE  = 16,
  parameter int FETCH_SIZE = 64,
  parameter int NUM_LINES  = 4,
  parameter int INDEX_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  d_cache_direct_if.slave       bus,
  inout  wire  [FETCH_SIZE-1:0] d_dataM,
  output logic [WORD_SIZE-1:0]  hit_count,
  output logic [WORD_SIZE-1:0]  miss_count
);
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, M_READ, M_WRITE} state_t;

  state_t                state, state_next;
  logic [2:0]            cnt;
  logic [NUM_LINES-1:0]  valid;
  logic [TAG_BITS-1:0]   tags  [NUM_LINES];
  logic [FETCH_SIZE-1:0] lines [NUM_LINES];
  logic [WORD_SIZE-1:0]  addr_q;
  logic [FETCH_SIZE-1:0] wline_q;
  logic                  refill;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   tag;
  logic [WORD_SIZE-1:0]  aligned;
  logic                  req, hit, burst_done;
  logic [FETCH_SIZE-1:0] merged;

  assign offset     = bus.d_addressC[1:0];
  assign index      = bus.d_addressC[INDEX_BITS+1:2];
  assign tag        = bus.d_addressC[WORD_SIZE-1:INDEX_BITS+2];
  assign aligned    = {bus.d_addressC[WORD_SIZE-1:2], 2'b00};
  assign fill_index = addr_q[INDEX_BITS+1:2];
  assign req        = bus.d_readC | bus.d_writeC;
  assign hit        = valid[index] && (tags[index] == tag);
  assign burst_done = (cnt == 3'd4);

  always_comb begin
    merged = lines[index];
    merged[32'(offset)*WORD_SIZE +: WORD_SIZE] = bus.d_wdataC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (!hit)              state_next = M_READ;
          else if (bus.d_writeC) state_next = M_WRITE;
        end
      end
      M_READ, M_WRITE: if (burst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.d_readM    = (state == M_READ);
    bus.d_writeM   = (state == M_WRITE);
    bus.d_addressM = addr_q;
    bus.d_readyC   = 1'b0;
    bus.d_rdataC   = '0;
    if (state == IDLE && bus.d_readC && hit) begin
      bus.d_readyC = 1'b1;
      bus.d_rdataC = lines[index][32'(offset)*WORD_SIZE +: WORD_SIZE];
    end
    if (state == M_WRITE && burst_done) bus.d_readyC = 1'b1;
  end

  assign d_dataM = (state == M_WRITE) ? wline_q : 'z;

  // A miss re-enters IDLE and completes as a hit; the refill flag keeps that
  // follow-up lookup from being counted as a genuine hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      valid      <= '0;
      addr_q     <= '0;
      wline_q    <= '0;
      refill     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cnt <= (state == IDLE || burst_done) ? 3'd0 : cnt + 3'd1;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              refill <= 1'b0;
              if (!refill) hit_count <= hit_count + WORD_SIZE'(1);
              if (bus.d_writeC) begin
                addr_q  <= aligned;
                wline_q <= merged;
              end
            end else begin
              addr_q     <= aligned;
              miss_count <= miss_count + WORD_SIZE'(1);
              refill     <= 1'b1;
            end
          end
        end
        M_READ: if (burst_done) valid[fill_index] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && bus.d_writeC) lines[index] <= merged;
    if (state == M_READ && burst_done) begin
      lines[fill_index] <= d_dataM;
      tags[fill_index]  <= addr_q[WORD_SIZE-1:INDEX_BITS+2];
    end
  end
endmodule

// File: tb/tb_d_cache_direct.sv
// Directed test of the direct-mapped data cache against a 4-state-burst memory model.
module tb_d_cache_direct;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] hit_count, miss_count;
  wire  [63:0] d_dataM;

  always #5 clk = ~clk;

  d_cache_direct_if #(.WORD_SIZE(16)) bus ();

  d_cache_direct #(
    .WORD_SIZE(16), .FETCH_SIZE(64), .NUM_LINES(4), .INDEX_BITS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .d_dataM(d_dataM),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Memory: FETCH0..3 after the first read-request edge, data driven in FETCH3;
  // STORE commits on the fifth write-request edge.
  logic [15:0]     mem [256];
  int unsigned     rd_cnt, wr_cnt;
  logic [7:0]      mbase;
  assign mbase   = bus.d_addressM[7:0];
  assign d_dataM = (bus.d_readM && rd_cnt == 4) ?
                   {mem[8'(mbase+3)], mem[8'(mbase+2)], mem[8'(mbase+1)], mem[mbase]} : 'z;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 ^ 16'(i);
      mem[8'h00] <= 16'h9023;
      mem[8'h01] <= 16'h0001;
      mem[8'h02] <= 16'hFFFF;
      mem[8'h03] <= 16'h1111;
      mem[8'h23] <= 16'h6000;
    end else begin
      rd_cnt <= bus.d_readM  ? rd_cnt + 1 : 0;
      wr_cnt <= bus.d_writeM ? wr_cnt + 1 : 0;
      if (bus.d_writeM && wr_cnt == 4)
        for (int k = 0; k < 4; k++) mem[8'(mbase + k)] <= d_dataM[16*k +: 16];
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          ready_cyc, rd_first, rd_last, wr_first, wr_last;
  logic        both_seen;
  logic [15:0] res_rdata, res_raddr, res_waddr;
  logic [63:0] res_line;

  // Starts just after a posedge; cycle 0 is the first cycle the request is visible.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    logic done = 1'b0;
    ready_cyc = -1; rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
    both_seen = 1'b0; res_rdata = '0; res_raddr = '0; res_waddr = '0; res_line = '0;
    bus.d_readC = !wr; bus.d_writeC = wr; bus.d_addressC = addr; bus.d_wdataC = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus.d_readM && bus.d_writeM) both_seen = 1'b1;
      if (bus.d_readM) begin
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc; res_raddr = bus.d_addressM;
      end
      if (bus.d_writeM) begin
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc; res_waddr = bus.d_addressM; res_line = d_dataM;
      end
      if (bus.d_readyC) begin
        done = 1'b1; ready_cyc = cyc; res_rdata = bus.d_rdataC;
      end
      @(posedge clk); #1;
    end
    check("ready_seen", 64'(done), 64'd1);
    bus.d_readC = 1'b0; bus.d_writeC = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.d_readC = 1'b0; bus.d_writeC = 1'b0; bus.d_addressC = '0; bus.d_wdataC = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readyC", 64'(bus.d_readyC), 64'd0);
    check("rst_readM",  64'(bus.d_readM),  64'd0);
    check("rst_writeM", 64'(bus.d_writeM), 64'd0);
    check("rst_addrM",  64'(bus.d_addressM), 64'd0);
    check("rst_hits",   64'(hit_count),  64'd0);
    check("rst_misses", 64'(miss_count), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Cold read miss
    access(1'b0, 16'h0001, 16'h0000);
    check("cold_rd_first", 64'(rd_first), 64'd1);
    check("cold_rd_last",  64'(rd_last),  64'd5);
    check("cold_addrM",    64'(res_raddr), 64'h0000);
    check("cold_ready",    64'(ready_cyc), 64'd6);
    check("cold_rdata",    64'(res_rdata), 64'h0001);
    check("cold_misses",   64'(miss_count), 64'd1);
    check("cold_hits",     64'(hit_count),  64'd0);

    // Zero-wait read hit
    access(1'b0, 16'h0002, 16'h0000);
    check("hit_ready", 64'(ready_cyc), 64'd0);
    check("hit_rdata", 64'(res_rdata), 64'hFFFF);
    check("hit_no_rdM", 64'(rd_first), 64'hFFFF_FFFF_FFFF_FFFF);
    check("hit_hits",  64'(hit_count), 64'd1);

    // Write hit -> write-through store
    access(1'b1, 16'h0003, 16'hABCD);
    check("wh_wr_first", 64'(wr_first), 64'd1);
    check("wh_wr_last",  64'(wr_last),  64'd5);
    check("wh_addrM",    64'(res_waddr), 64'h0000);
    check("wh_line",     res_line, 64'hABCD_FFFF_0001_9023);
    check("wh_ready",    64'(ready_cyc), 64'd5);
    check("wh_mem3",     64'(mem[8'h03]), 64'hABCD);
    access(1'b0, 16'h0003, 16'h0000);
    check("wh_rd_ready", 64'(ready_cyc), 64'd0);
    check("wh_rd_data",  64'(res_rdata), 64'hABCD);
    check("wh_hits",     64'(hit_count), 64'd3);

    // Conflict misses on index 0
    access(1'b0, 16'h0023, 16'h0000);
    check("cf1_addrM", 64'(res_raddr), 64'h0020);
    check("cf1_ready", 64'(ready_cyc), 64'd6);
    check("cf1_rdata", 64'(res_rdata), 64'h6000);
    access(1'b0, 16'h0000, 16'h0000);
    check("cf2_addrM",  64'(res_raddr), 64'h0000);
    check("cf2_ready",  64'(ready_cyc), 64'd6);
    check("cf2_rdata",  64'(res_rdata), 64'h9023);
    check("cf2_misses", 64'(miss_count), 64'd3);
    check("cf2_hits",   64'(hit_count),  64'd3);

    // Write miss: refill, then store of the merged line
    access(1'b1, 16'h0045, 16'h1234);
    check("wm_rd_first", 64'(rd_first), 64'd1);
    check("wm_rd_last",  64'(rd_last),  64'd5);
    check("wm_raddr",    64'(res_raddr), 64'h0044);
    check("wm_wr_first", 64'(wr_first), 64'd7);
    check("wm_wr_last",  64'(wr_last),  64'd11);
    check("wm_waddr",    64'(res_waddr), 64'h0044);
    check("wm_line",     res_line, 64'hA047_A046_1234_A044);
    check("wm_ready",    64'(ready_cyc), 64'd11);
    check("wm_both",     64'(both_seen), 64'd0);
    check("wm_mem45",    64'(mem[8'h45]), 64'h1234);
    check("wm_misses",   64'(miss_count), 64'd4);
    check("wm_hits",     64'(hit_count),  64'd3);

    // Reset during M_READ cycle 2
    bus.d_readC = 1'b1; bus.d_addressC = 16'h0021;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mr_readM_before", 64'(bus.d_readM), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mr_readM",  64'(bus.d_readM),  64'd0);
    check("mr_writeM", 64'(bus.d_writeM), 64'd0);
    check("mr_addrM",  64'(bus.d_addressM), 64'd0);
    check("mr_misses", 64'(miss_count), 64'd0);
    check("mr_hits",   64'(hit_count),  64'd0);
    bus.d_readC = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 16'h0001, 16'h0000);
    check("rr_rd_first", 64'(rd_first), 64'd1);
    check("rr_rd_last",  64'(rd_last),  64'd5);
    check("rr_ready",    64'(ready_cyc), 64'd6);
    check("rr_rdata",    64'(res_rdata), 64'h0001);
    check("rr_misses",   64'(miss_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/d_cache_direct.md
Name: d_cache_direct

Overview:
- Direct-mapped, write-through, write-allocate data cache between the CPU data port and the 4-word-burst data memory port (d_readM / d_writeM / d_addressM / d_dataM).
- Serves 16-bit word accesses from the CPU.
- Refills and writes back whole 4-word (64-bit) lines using the memory's fixed 4-state FETCH and STORE sequences.
- Keeps hit and miss counters for performance reporting.

Parameters:
- WORD_SIZE, 16, CPU word and address width.
- FETCH_SIZE, 64, line width; 4 words.
- NUM_LINES, 4, number of cache lines; power of 2.
- INDEX_BITS, 2, log2(NUM_LINES).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  reset; asynchronous, active-low.
- d_readC  input  1  CPU read request; held until d_readyC.
- d_writeC  input  1  CPU write request; held until d_readyC; never asserted together with d_readC.
- d_addressC  input  16  CPU word address; stable while request held.
- d_wdataC  input  16  CPU write data.
- d_rdataC  output  16  read data; valid when d_readyC=1 on a read.
- d_readyC  output  1  access-complete strobe, one cycle per access.
- d_readM  output  1  memory line-read request.
- d_writeM  output  1  memory line-write request.
- d_addressM  output  16  line-aligned memory address; bits [1:0]=0.
- d_dataM  inout  64  memory data bus; word k at bits [16k+15:16k]. Driven only in M_WRITE, else high-Z.
- hit_count  output  16  completed lookup hits; wraps.
- miss_count  output  16  refills started; wraps.

Behaviour:
- Address split: offset=addr[1:0], index=addr[INDEX_BITS+1:2], tag=remaining upper bits.
- Storage per line: valid bit, tag, 64-bit data.
- Reset (async, any state, including mid-burst):
  - state=IDLE; all valid=0.
  - d_readM=0, d_writeM=0, d_addressM=0, d_dataM=Z.
  - d_readyC=0, d_rdataC=0, counters=0, refill flag=0.
  - Memory shares reset_n, so no burst survives reset.
- Lookup hit = valid[index] && tag match.
- States:
  - IDLE, no request: all memory requests 0.
  - IDLE, read hit:
    - d_readyC=1 and d_rdataC=selected word, combinationally in the same cycle (zero wait).
    - Stay IDLE.
  - IDLE, write hit:
    - At the clock edge, merge d_wdataC into the line at offset.
    - Latch the aligned address and the merged line.
    - Go to M_WRITE.
  - IDLE, read or write miss: latch the aligned address, increment miss_count, set refill flag, go to M_READ.
  - M_READ: exactly 5 cycles (3-bit counter 0..4).
    - d_readM=1 and d_addressM held for all 5 cycles.
    - Memory enters FETCH0 after the first edge and drives data during cycle 4.
    - At the end of cycle 4: capture d_dataM into the line, write tag, set valid, deassert d_readM, return to IDLE.
    - The access then completes as a hit in IDLE.
  - M_WRITE: exactly 5 cycles.
    - d_writeM=1 and d_addressM held; d_dataM driven with the merged line for all 5 cycles.
    - Memory commits at the end of cycle 4 (STORE3).
    - d_readyC=1 during cycle 4 only.
    - Then release the bus to Z and return to IDLE.
- hit_count: increments on an IDLE lookup hit only when the refill flag=0. The refill flag clears on any IDLE hit.
- Latency from request cycle 0:
  - read hit: 0
  - write hit: ready at cycle 5
  - read miss: ready at cycle 6
  - write miss: ready at cycle 11
- Timing boundaries:
  - d_readM and d_writeM are never both 1.
  - Both requests are 0 in IDLE, so memory always returns to RESET before the next burst.
- Eviction: a miss on a valid line overwrites it with no writeback, since the design is write-through.
- The CPU may present a new request in the cycle after d_readyC.

Test Plan:
- Cold read: after reset, read 0x0001.
  - d_readM=1 with d_addressM=0x0000 during cycles 1-5.
  - d_readyC=1 at cycle 6, d_rdataC=0x0001.
  - miss_count=1, hit_count=0.
- Hit: then read 0x0002.
  - d_readyC=1 in the same cycle, d_rdataC=0xFFFF.
  - hit_count=1.
  - d_readM stays 0.
- Write hit: write 0xABCD to 0x0003.
  - d_writeM=1 during cycles 1-5 with d_addressM=0x0000.
  - d_dataM=0xABCD_FFFF_0001_9023.
  - d_readyC at cycle 5.
  - A following read of 0x0003 returns 0xABCD with zero wait.
- Conflict: read 0x0023.
  - Same index 0, miss; d_addressM=0x0020; returns 0x6000.
  - Then read 0x0000: miss again, returns 0x9023; miss_count increments.
- Write miss: write 0x1234 to 0x0045.
  - d_readM during cycles 1-5 at 0x0044.
  - d_writeM during cycles 7-11 with the merged line.
  - d_readyC at cycle 11; memory word 0x45=0x1234.
- Reset mid-refill: assert reset_n=0 during M_READ cycle 2.
  - d_readM=0 immediately and d_dataM=Z.
  - Then re-read 0x0001: misses, with the full 5-cycle refill.
